// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, MEM-stage FSM states, byte enables and load/store decode helpers (BYTE_ACCESS_EN adds sub-word ops)
package mips_pkg;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LBU = 6'h24, OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29;
  localparam logic [3:0] BE_WORD = 4'hF, BE_LO = 4'h3, BE_HI = 4'hC, BE_B0 = 4'h1;
  typedef enum logic {IDLE, ACCESS} mau_state_t;
  function automatic logic is_load(input logic [5:0] op);
`ifdef BYTE_ACCESS_EN
    return op inside {OP_LW, OP_LB, OP_LH, OP_LBU, OP_LHU};
`else
    return op == OP_LW;
`endif
  endfunction
  function automatic logic is_store(input logic [5:0] op);
`ifdef BYTE_ACCESS_EN
    return op inside {OP_SW, OP_SB, OP_SH};
`else
    return op == OP_SW;
`endif
  endfunction
endpackage

// File: rtl/load_align_ext.sv
// load_align_ext: picks the addressed byte/halfword lane of a read word and sign/zero-extends it (built only with BYTE_ACCESS_EN)
// ports: op (load opcode), off (byte offset), rdata (bus word) -> data (register value)
`ifdef BYTE_ACCESS_EN
module load_align_ext
  import mips_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[8*off +: 8];
  assign h = off[1] ? rdata[31:16] : rdata[15:0];
  always_comb
    data = op == OP_LB  ? {{24{b[7]}}, b} :
           op == OP_LBU ? {24'b0, b} :
           op == OP_LH  ? {{16{h[15]}}, h} :
           op == OP_LHU ? {16'b0, h} : rdata;
endmodule
`endif

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage engine; runs LW/SW (and sub-word ops with BYTE_ACCESS_EN) as req/ack bus transactions, passes other instructions through
// ports: clk, reset (async active-low); EX/MEM inputs in_valid/instructionin/addressin/aluin/zeroin/datain; stall back to EX/MEM;
//        dmem_* data-memory bus; MEM/WB outputs out_valid/instructionout/addressout/aluout/zeroout/memdataout/err
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       instructionin,
  input  logic [31:0]       addressin,
  input  logic [31:0]       aluin,
  input  logic              zeroin,
  input  logic [31:0]       datain,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              out_valid,
  output logic [31:0]       instructionout,
  output logic [31:0]       addressout,
  output logic [31:0]       aluout,
  output logic              zeroout,
  output logic [31:0]       memdataout,
  output logic              err
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  mau_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [5:0] op;
  logic mem_op, mis, timeout;
  logic [3:0] be;
  logic [31:0] wd, ld_data;
  assign op = instructionin[31:26];
  assign mem_op = is_load(op) || is_store(op);
  assign stall = state == ACCESS;
  assign timeout = TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES - 1);
`ifdef BYTE_ACCESS_EN
  logic byte_op, half_op;
  assign byte_op = op inside {OP_LB, OP_LBU, OP_SB};
  assign half_op = op inside {OP_LH, OP_LHU, OP_SH};
  assign mis = byte_op ? 1'b0 : half_op ? aluin[0] : aluin[1:0] != 2'b00;
  assign be = byte_op ? BE_B0 << aluin[1:0] : half_op ? (aluin[1] ? BE_HI : BE_LO) : BE_WORD;
  assign wd = byte_op ? {4{datain[7:0]}} : half_op ? {2{datain[15:0]}} : datain;
  // the accepted instruction and its address stay in the pass-through registers for the whole access
  load_align_ext u_ext (.op(instructionout[31:26]), .off(aluout[1:0]), .rdata(dmem_rdata), .data(ld_data));
`else
  assign mis = aluin[1:0] != 2'b00;
  assign be = BE_WORD;
  assign wd = datain;
  assign ld_data = dmem_rdata;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (in_valid && mem_op && !mis ? ACCESS : IDLE) :
              (dmem_ack || timeout ? IDLE : ACCESS);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_be <= 4'h0;
      dmem_wdata <= '0;
      out_valid <= 1'b0;
      err <= 1'b0;
      memdataout <= '0;
      instructionout <= '0;
      addressout <= '0;
      aluout <= '0;
      zeroout <= 1'b0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        instructionout <= instructionin;
        addressout <= addressin;
        aluout <= aluin;
        zeroout <= zeroin;
        memdataout <= '0;
        cnt <= '0;
        if (mem_op && !mis) begin
          dmem_req <= 1'b1;
          dmem_we <= is_store(op);
          dmem_addr <= {aluin[ADDR_W-1:2], 2'b00};
          dmem_be <= be;
          dmem_wdata <= wd;
          out_valid <= 1'b0;
        end else begin
          out_valid <= 1'b1;
          err <= mem_op;
        end
      end else out_valid <= 1'b0;
    end else if (dmem_ack) begin
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      out_valid <= 1'b1;
      err <= 1'b0;
      memdataout <= is_load(instructionout[31:26]) ? ld_data : '0;
    end else if (timeout) begin
      dmem_req <= 1'b0;
      out_valid <= 1'b1;
      err <= 1'b1;
      memdataout <= '0;
    end else cnt <= cnt + 1'b1;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit; sub-word cases follow BYTE_ACCESS_EN
module tb_mem_access_unit;
  logic clk = 0, reset = 0, in_valid = 0, zeroin = 0, dmem_ack = 0;
  logic [31:0] instructionin = 0, addressin = 0, aluin = 0, datain = 0, dmem_rdata = 0;
  logic stall, dmem_req, dmem_we, out_valid, zeroout, err;
  logic [31:0] dmem_addr, dmem_wdata, instructionout, addressout, aluout, memdataout;
  logic [3:0] dmem_be;
  typedef struct {logic [31:0] instr, pc, alu, mem; logic zero, err;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0;
  bit ok;
  localparam logic [31:0] ADD = 32'h012A4020, LW = 32'h8C080000, SW = 32'hAC080000;
  localparam logic [31:0] LB = 32'h80080000, LBU = 32'h90080000, SH = 32'hA4080000;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instructionin(instructionin),
    .addressin(addressin), .aluin(aluin), .zeroin(zeroin), .datain(datain), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .out_valid(out_valid),
    .instructionout(instructionout), .addressout(addressout), .aluout(aluout), .zeroout(zeroout),
    .memdataout(memdataout), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, pc, alu, input logic z, input logic [31:0] d, mem, input logic er);
    instructionin = instr; addressin = pc; aluin = alu; zeroin = z; datain = d; in_valid = 1;
    sb.push_back('{instr: instr, pc: pc, alu: alu, mem: mem, zero: z, err: er});
    step();
    in_valid = 0;
  endtask

  task automatic wait_out(input int lim, output bit got);
    for (int k = 0; k < lim && out_valid !== 1'b1; k++) step();
    got = out_valid === 1'b1;
  endtask

  task automatic pop_cmp(input string name, input bit got);
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: got scoreboard empty want an entry", name);
    end else begin
      e = sb.pop_front();
      if (!got || {instructionout, addressout, aluout, zeroout, memdataout, err} !== {e.instr, e.pc, e.alu, e.zero, e.mem, e.err}) begin
        n_bad++;
        $display("FAIL %s: got v=%b i=%h pc=%h alu=%h z=%b md=%h err=%b want i=%h pc=%h alu=%h z=%b md=%h err=%b",
                 name, out_valid, instructionout, addressout, aluout, zeroout, memdataout, err,
                 e.instr, e.pc, e.alu, e.zero, e.mem, e.err);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, out_valid, err, memdataout, instructionout, addressout, aluout, zeroout, stall} !== '0) begin
      n_bad++; $display("FAIL reset_state: got req=%b v=%b i=%h md=%h stall=%b want all zero", dmem_req, out_valid, instructionout, memdataout, stall);
    end
    step(); reset = 1; step();
    issue(LW, 32'h40, 32'h100, 0, 0, 0, 0);
    n_cmp++;
    if (dmem_req !== 1'b1) begin n_bad++; $display("FAIL reset_pre_req: got %b want 1", dmem_req); end
    #2 reset = 0;
    #1;
    n_cmp++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, out_valid, err, memdataout, instructionout, addressout, aluout, zeroout, stall} !== '0) begin
      n_bad++; $display("FAIL reset_mid_access: got req=%b we=%b be=%h i=%h stall=%b want all zero", dmem_req, dmem_we, dmem_be, instructionout, stall);
    end
    #1 reset = 1;
    sb.delete();
    step();
    dmem_ack = 1; dmem_rdata = 32'h11111111;
    step();
    dmem_ack = 0; dmem_rdata = 0;
    n_cmp++;
    if ({out_valid, dmem_req, stall} !== 3'b000) begin
      n_bad++; $display("FAIL reset_ack_ignored: got v=%b req=%b stall=%b want 000", out_valid, dmem_req, stall);
    end
  endtask

  task automatic test_passthrough();
    issue(ADD, 32'h1000, 32'h5, 1, 32'h77, 0, 0);
    n_cmp++;
    if ({stall, dmem_req} !== 2'b00) begin n_bad++; $display("FAIL add_stall: got stall=%b req=%b want 00", stall, dmem_req); end
    pop_cmp("add_out", out_valid === 1'b1);
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_pulse: got %b want 0", out_valid); end
  endtask

  task automatic test_lw();
    int sc = 0;
    issue(LW, 32'h1004, 32'h100, 0, 0, 32'hDEADBEEF, 0);
    n_cmp++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be} !== {1'b1, 1'b0, 32'h100, 4'hF}) begin
      n_bad++; $display("FAIL lw_bus: got req=%b we=%b addr=%h be=%h want 1 0 00000100 f", dmem_req, dmem_we, dmem_addr, dmem_be);
    end
    for (int i = 0; i < 3; i++) begin
      sc += (stall === 1'b1 && dmem_req === 1'b1) ? 1 : 0;
      if (i == 2) begin dmem_ack = 1; dmem_rdata = 32'hDEADBEEF; end
      step();
      dmem_ack = 0; dmem_rdata = 0;
    end
    n_cmp++;
    if (sc != 3 || stall !== 1'b0) begin n_bad++; $display("FAIL lw_stall: got %0d cycles (stall now %b) want 3", sc, stall); end
    pop_cmp("lw_out", out_valid === 1'b1);
  endtask

  task automatic test_back_to_back();
    instructionin = SW; addressin = 32'h1008; aluin = 32'h104; datain = 32'h12345678; zeroin = 0; in_valid = 1;
    sb.push_back('{instr: SW, pc: 32'h1008, alu: 32'h104, mem: 0, zero: 0, err: 0});
    step();
    instructionin = ADD; addressin = 32'h100C; aluin = 32'h5; datain = 0; zeroin = 0;
    sb.push_back('{instr: ADD, pc: 32'h100C, alu: 32'h5, mem: 0, zero: 0, err: 0});
    dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
    n_cmp++;
    if ({stall, dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 1'b1, 32'h104, 32'h12345678}) begin
      n_bad++; $display("FAIL sw_bus: got stall=%b req=%b we=%b addr=%h wd=%h want 1 1 1 00000104 12345678", stall, dmem_req, dmem_we, dmem_addr, dmem_wdata);
    end
    step();
    dmem_ack = 0; dmem_rdata = 0;
    n_cmp++;
    if ({stall, dmem_req, dmem_we} !== 3'b000) begin n_bad++; $display("FAIL sw_release: got stall=%b req=%b we=%b want 000", stall, dmem_req, dmem_we); end
    pop_cmp("sw_out", out_valid === 1'b1);
    step();
    in_valid = 0;
    pop_cmp("b2b_add_out", out_valid === 1'b1);
  endtask

  task automatic test_misaligned();
    issue(LW, 32'h1010, 32'h102, 0, 0, 0, 1);
    n_cmp++;
    if ({dmem_req, stall} !== 2'b00) begin n_bad++; $display("FAIL mis_req: got req=%b stall=%b want 00", dmem_req, stall); end
    pop_cmp("mis_out", out_valid === 1'b1);
  endtask

  task automatic test_timeout();
    int rc = 0;
    issue(LW, 32'h1014, 32'h108, 0, 0, 0, 1);
    wait_out(0, ok);
    for (int k = 0; k < 40 && out_valid !== 1'b1; k++) begin
      rc += dmem_req === 1'b1 ? 1 : 0;
      step();
    end
    n_cmp++;
    if (rc != 16 || dmem_req !== 1'b0) begin n_bad++; $display("FAIL timeout_len: got %0d req cycles (req now %b) want 16", rc, dmem_req); end
    pop_cmp("timeout_out", out_valid === 1'b1);
    step();
  endtask

  task automatic test_byte();
`ifdef BYTE_ACCESS_EN
    issue(LB, 32'h1018, 32'h203, 0, 0, 32'hFFFFFF80, 0);
    n_cmp++;
    if ({dmem_req, dmem_addr, dmem_be} !== {1'b1, 32'h200, 4'b1000}) begin
      n_bad++; $display("FAIL lb_bus: got req=%b addr=%h be=%b want 1 00000200 1000", dmem_req, dmem_addr, dmem_be);
    end
    dmem_ack = 1; dmem_rdata = 32'h80FF0011;
    step();
    dmem_ack = 0; dmem_rdata = 0;
    pop_cmp("lb_out", out_valid === 1'b1);
    issue(LBU, 32'h101C, 32'h203, 0, 0, 32'h00000080, 0);
    dmem_ack = 1; dmem_rdata = 32'h80FF0011;
    step();
    dmem_ack = 0; dmem_rdata = 0;
    pop_cmp("lbu_out", out_valid === 1'b1);
    issue(SH, 32'h1020, 32'h201, 0, 32'hABCD, 0, 1);
    n_cmp++;
    if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL sh_mis_req: got %b want 0", dmem_req); end
    pop_cmp("sh_mis_out", out_valid === 1'b1);
`else
    issue(LB, 32'h1018, 32'h203, 0, 0, 0, 0);
    n_cmp++;
    if ({dmem_req, stall} !== 2'b00) begin n_bad++; $display("FAIL lb_plain_req: got req=%b stall=%b want 00", dmem_req, stall); end
    pop_cmp("lb_plain_out", out_valid === 1'b1);
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lw();
    test_back_to_back();
    test_misaligned();
    test_timeout();
    test_byte();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage engine sitting downstream of the EX/MEM pipeline register; consumes its instruction, PC, ALU result, store data and zero-flag outputs.
- Decodes LW/SW and runs a req/ack transaction on the data-memory bus; passes every other instruction through in one cycle.
- Feeds the MEM/WB register and drives a stall back to the EX/MEM register while a memory transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: max ACCESS cycles without ack before abort; 0 disables the timeout.
- ADDR_W, 32: data-memory byte-address width, ≤ 32; dmem_addr = aluin[ADDR_W-1:0] word-aligned.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- in_valid  in  1  EX/MEM holds a valid instruction
- instructionin  in  32  instruction word; opcode = [31:26]
- addressin  in  32  PC of the instruction
- aluin  in  32  ALU result / effective byte address
- zeroin  in  1  ALU zero flag
- datain  in  32  store data (rt value)
- stall  out  1  hold EX/MEM contents; combinational = (state == ACCESS)
- dmem_req  out  1  bus request, registered
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word-aligned byte address, low 2 bits = 0
- dmem_be  out  4  byte enables, bit i = byte lane i (little-endian)
- dmem_wdata  out  32  write data
- dmem_rdata  in  32  read data, valid with ack
- dmem_ack  in  1  one-cycle completion pulse
- out_valid  out  1  one-cycle pulse: outputs below are valid for MEM/WB
- instructionout  out  32  instruction passed on
- addressout  out  32  PC passed on
- aluout  out  32  ALU result passed on
- zeroout  out  1  zero flag passed on
- memdataout  out  32  load data (0 for non-loads)
- err  out  1  misaligned access or timeout; valid with out_valid

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE; timeout counter 0; every output register 0, including dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, out_valid, err, memdataout, instructionout, addressout, aluout, zeroout.
- Reset mid-ACCESS abandons the transaction; req drops immediately.
- An ack arriving while not in ACCESS is ignored.
- States: IDLE, ACCESS.
- IDLE, in_valid = 0:
  - out_valid <= 0; data outputs hold.
- IDLE, in_valid = 1: instruction accepted that cycle (stall = 0). The pass-through registers (instruction, address, alu, zero) are always latched.
  - Non-memory opcode: next cycle out_valid = 1, memdataout = 0, err = 0.
  - LW (0x23) or SW (0x2B) with aluin[1:0] != 0: no bus cycle; next cycle out_valid = 1, err = 1, memdataout = 0.
  - Aligned LW/SW: next state ACCESS. Register dmem_req = 1, dmem_we = (SW), dmem_addr, dmem_be = 4'hF, dmem_wdata = datain. out_valid <= 0; counter cleared.
- ACCESS: stall = 1. Bus outputs are held stable until ack.
  - dmem_ack = 1:
    - dmem_req <= 0 and dmem_we <= 0; state IDLE.
    - out_valid <= 1 and err <= 0.
    - memdataout <= dmem_rdata for LW, 0 for SW.
  - No ack and TIMEOUT_CYCLES != 0: counter increments each cycle. When the counter reaches TIMEOUT_CYCLES - 1 (TIMEOUT_CYCLES ACCESS cycles without ack):
    - dmem_req <= 0; state IDLE.
    - out_valid <= 1, err <= 1, memdataout <= 0.
- Latency: pass-through is 1 cycle. Memory op: accept at T, req visible from T+1, earliest ack at T+1, out_valid at T+2. In general out_valid = ack cycle + 1.
- Back-to-back: the cycle after ack, state is IDLE and the held EX/MEM instruction is accepted.
- in_valid is ignored while in ACCESS.

Optional Feature:
- Macro BYTE_ACCESS_EN.
- Defined:
  - Adds LB 0x20, LH 0x21, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29.
  - dmem_be selects lane(s) from aluin[1:0].
  - Store data is replicated across lanes.
  - Loads extract the lane and sign- or zero-extend.
  - Halfword with aluin[0] = 1 is misaligned (err path); bytes are never misaligned.
- Undefined: these opcodes are treated as non-memory pass-through; dmem_be is always 4'hF.

Decomposition:
- Shared package mips_pkg:
  - opcode constants (OP_LW, OP_SW, OP_LB, …)
  - mau_state_t enum {IDLE, ACCESS}
  - byte-enable constants
- One natural sub-module: load_align_ext (combinational lane select + sign/zero extension). Instantiated only under BYTE_ACCESS_EN; otherwise LW data is direct.

Test Plan:
- Reset: drive reset = 0 mid-ACCESS with dmem_req = 1 → dmem_req = 0 and all outputs 0 within the same cycle; an ack 1 cycle later is ignored and out_valid stays 0.
- ADD pass-through: in_valid = 1, instr 0x012A4020, aluin 0x5 → next cycle out_valid = 1, aluout 0x5, memdataout 0, stall never 1.
- LW aluin 0x100:
  - Ack 3 cycles after req with rdata 0xDEADBEEF → dmem_addr 0x100, we 0, be F.
  - Stall high for exactly the 3 ACCESS cycles.
  - out_valid 1 cycle after ack with memdataout 0xDEADBEEF, err 0.
- SW aluin 0x104, datain 0x12345678, ack immediate → we 1, wdata 0x12345678, out_valid at T+2, memdataout 0; a following ADD is accepted at T+2.
- LW aluin 0x102 → no dmem_req, next cycle err = 1, out_valid = 1. Separately, LW with ack withheld, TIMEOUT_CYCLES = 16 → req drops after 16 ACCESS cycles, err = 1.
- BYTE_ACCESS_EN:
  - LB aluin 0x203, rdata 0x80FF0011 → be 4'b1000, memdataout 0xFFFFFF80.
  - LBU at the same address → 0x00000080.
  - SH aluin 0x201 → err = 1.
